// File: rtl/i2c_reg_sequencer_if.sv
// Host command/response and i2c_controller handshake bundle for i2c_reg_sequencer.
// slave = the sequencer; master = the host plus the byte-level controller it drives.
interface i2c_reg_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [6:0] cmd_dev_addr;
    logic [7:0] cmd_reg_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic       busy;

    logic [6:0] ctl_addr;
    logic       ctl_rw;
    logic       ctl_start;
    logic [7:0] ctl_data;
    logic       ctl_write_en;
    logic       ctl_read_en;
    logic       ctl_send_ack;
    logic       ctl_send_nack;
    logic       ctl_send_stop;
    logic [7:0] ctl_data_out;
    logic       ctl_ack;
    logic       ctl_nack;
    logic       ctl_ongoing;
    logic       ctl_idle;

    modport slave (
        input  cmd_valid, cmd_rw, cmd_dev_addr, cmd_reg_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        output ctl_addr, ctl_rw, ctl_start, ctl_data, ctl_write_en, ctl_read_en,
        output ctl_send_ack, ctl_send_nack, ctl_send_stop,
        input  ctl_data_out, ctl_ack, ctl_nack, ctl_ongoing, ctl_idle
    );

    modport master (
        output cmd_valid, cmd_rw, cmd_dev_addr, cmd_reg_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        input  ctl_addr, ctl_rw, ctl_start, ctl_data, ctl_write_en, ctl_read_en,
        input  ctl_send_ack, ctl_send_nack, ctl_send_stop,
        output ctl_data_out, ctl_ack, ctl_nack, ctl_ongoing, ctl_idle
    );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// Runs one 8-bit-register write or read per host command on top of the byte-level i2c_controller.
// Define I2C_SEQ_REPSTART_EN to use a repeated START (no STOP) between the reg_addr and read phases.
module i2c_reg_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned GUARD_CYCLES   = 2
) (
    input logic                clk,
    input logic                reset,
    i2c_reg_sequencer_if.slave bus
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GUARD_CYCLES);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ADDR    = 2'd1;
    localparam logic [1:0] ERR_DATA    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START_ISSUE,
        S_START_WAIT,
        S_REG_ISSUE,
        S_REG_WAIT,
        S_DATA_ISSUE,
        S_DATA_WAIT,
        S_STOP_ISSUE,
        S_STOP_WAIT,
        S_RSTART_ISSUE,
        S_RSTART_WAIT,
        S_NACK_ISSUE,
        S_NACK_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    logic [7:0]    reg_q;
    logic [7:0]    wdata_q;
    logic          rw_q;
    logic [1:0]    err_q;
    logic          restart_pending;
    logic [GW-1:0] guard_cnt;
    logic [TW-1:0] wait_cnt;

    logic          cmd_ready_q;
    logic          rsp_valid_q;
    logic [7:0]    rsp_rdata_q;
    logic [1:0]    rsp_err_q;
    logic [6:0]    ctl_addr_q;
    logic          ctl_rw_q;
    logic [7:0]    ctl_data_q;
    logic          ctl_start_q;
    logic          ctl_write_en_q;
    logic          ctl_send_nack_q;
    logic          ctl_send_stop_q;

    logic          guard_done;
    logic          stop_like;
    logic          wait_ready;
    logic          is_issue;

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.busy          = ~cmd_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.ctl_addr      = ctl_addr_q;
    assign bus.ctl_rw        = ctl_rw_q;
    assign bus.ctl_data      = ctl_data_q;
    assign bus.ctl_start     = ctl_start_q;
    assign bus.ctl_write_en  = ctl_write_en_q;
    assign bus.ctl_send_nack = ctl_send_nack_q;
    assign bus.ctl_send_stop = ctl_send_stop_q;
    assign bus.ctl_read_en   = 1'b0;
    assign bus.ctl_send_ack  = 1'b0;

    always_comb begin
        guard_done = (guard_cnt == G_LAST);
        // A STOP (explicit or the one following a master NACK) must also release the bus.
        stop_like  = (state == S_STOP_WAIT) || (state == S_NACK_WAIT);
        wait_ready = guard_done && bus.ctl_idle && !(stop_like && bus.ctl_ongoing);
        is_issue   = (state == S_START_ISSUE) || (state == S_REG_ISSUE) ||
                     (state == S_DATA_ISSUE) || (state == S_STOP_ISSUE) ||
                     (state == S_RSTART_ISSUE) || (state == S_NACK_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            reg_q           <= 8'h00;
            wdata_q         <= 8'h00;
            rw_q            <= 1'b0;
            err_q           <= ERR_OK;
            restart_pending <= 1'b0;
            guard_cnt       <= '0;
            wait_cnt        <= '0;
            cmd_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= 8'h00;
            rsp_err_q       <= ERR_OK;
            ctl_addr_q      <= 7'h00;
            ctl_rw_q        <= 1'b0;
            ctl_data_q      <= 8'h00;
            ctl_start_q     <= 1'b0;
            ctl_write_en_q  <= 1'b0;
            ctl_send_nack_q <= 1'b0;
            ctl_send_stop_q <= 1'b0;
        end else begin
            ctl_start_q     <= 1'b0;
            ctl_write_en_q  <= 1'b0;
            ctl_send_nack_q <= 1'b0;
            ctl_send_stop_q <= 1'b0;
            rsp_valid_q     <= 1'b0;

            if (is_issue) begin
                guard_cnt <= '0;
                wait_cnt  <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        reg_q           <= bus.cmd_reg_addr;
                        wdata_q         <= bus.cmd_wdata;
                        rw_q            <= bus.cmd_rw;
                        ctl_addr_q      <= bus.cmd_dev_addr;
                        ctl_data_q      <= bus.cmd_reg_addr;
                        ctl_rw_q        <= 1'b0;
                        err_q           <= ERR_OK;
                        restart_pending <= 1'b0;
                        rsp_rdata_q     <= 8'h00;
                        cmd_ready_q     <= 1'b0;
                        ctl_start_q     <= 1'b1;
                        state           <= S_START_ISSUE;
                    end
                end

                S_START_ISSUE:  state <= S_START_WAIT;
                S_REG_ISSUE:    state <= S_REG_WAIT;
                S_DATA_ISSUE:   state <= S_DATA_WAIT;
                S_STOP_ISSUE:   state <= S_STOP_WAIT;
                S_RSTART_ISSUE: state <= S_RSTART_WAIT;
                S_NACK_ISSUE:   state <= S_NACK_WAIT;

                S_START_WAIT, S_REG_WAIT, S_DATA_WAIT,
                S_STOP_WAIT, S_RSTART_WAIT, S_NACK_WAIT: begin
                    if (!guard_done) begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end else if (wait_ready) begin
                        case (state)
                            S_START_WAIT: begin
                                if (bus.ctl_nack) begin
                                    err_q           <= ERR_ADDR;
                                    ctl_send_stop_q <= 1'b1;
                                    state           <= S_STOP_ISSUE;
                                end else begin
                                    ctl_data_q     <= reg_q;
                                    ctl_write_en_q <= 1'b1;
                                    state          <= S_REG_ISSUE;
                                end
                            end
                            S_REG_WAIT: begin
                                if (bus.ctl_nack) begin
                                    err_q           <= ERR_DATA;
                                    ctl_send_stop_q <= 1'b1;
                                    state           <= S_STOP_ISSUE;
                                end else if (!rw_q) begin
                                    ctl_data_q     <= wdata_q;
                                    ctl_write_en_q <= 1'b1;
                                    state          <= S_DATA_ISSUE;
                                end else begin
`ifdef I2C_SEQ_REPSTART_EN
                                    ctl_rw_q    <= 1'b1;
                                    ctl_start_q <= 1'b1;
                                    state       <= S_RSTART_ISSUE;
`else
                                    restart_pending <= 1'b1;
                                    ctl_send_stop_q <= 1'b1;
                                    state           <= S_STOP_ISSUE;
`endif
                                end
                            end
                            S_DATA_WAIT: begin
                                if (bus.ctl_nack) begin
                                    err_q <= ERR_DATA;
                                end
                                ctl_send_stop_q <= 1'b1;
                                state           <= S_STOP_ISSUE;
                            end
                            S_STOP_WAIT: begin
                                if (restart_pending) begin
                                    restart_pending <= 1'b0;
                                    ctl_rw_q        <= 1'b1;
                                    ctl_start_q     <= 1'b1;
                                    state           <= S_RSTART_ISSUE;
                                end else begin
                                    rsp_err_q   <= err_q;
                                    rsp_valid_q <= 1'b1;
                                    state       <= S_DONE;
                                end
                            end
                            S_RSTART_WAIT: begin
                                // The controller has already clocked in the data byte on address ack.
                                if (bus.ctl_nack) begin
                                    err_q           <= ERR_ADDR;
                                    ctl_send_stop_q <= 1'b1;
                                    state           <= S_STOP_ISSUE;
                                end else begin
                                    if (bus.ctl_ack) begin
                                        rsp_rdata_q <= bus.ctl_data_out;
                                    end
                                    ctl_send_nack_q <= 1'b1;
                                    state           <= S_NACK_ISSUE;
                                end
                            end
                            default: begin
                                rsp_err_q   <= err_q;
                                rsp_valid_q <= 1'b1;
                                state       <= S_DONE;
                            end
                        endcase
                    end else if (wait_cnt == T_LAST) begin
                        // Abandon without STOP; the controller is assumed wedged.
                        rsp_err_q   <= ERR_TIMEOUT;
                        rsp_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    cmd_ready_q <= 1'b1;
                    state       <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Self-checking bench for i2c_reg_sequencer: a byte-level controller/slave model on the ctl_* side
// and a transaction-level expectation model of bus tokens and responses.
module tb_i2c_reg_sequencer;

    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned GUARD   = 2;
    localparam int          LAT     = 6;
    localparam int          TOK_S   = 'h100;
    localparam int          TOK_P   = 'h200;
    localparam int          TOK_N   = 'h300;
    localparam logic [6:0]  SLAVE_DEV = 7'h50;

    logic clk = 1'b0;
    logic reset;

    i2c_reg_sequencer_if bus ();

    i2c_reg_sequencer #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .GUARD_CYCLES  (GUARD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   rsp_cyc = 0;
    bit   hang = 1'b0;
    bit   nack_reg_en = 1'b0;
    int   bus_log[$];
    logic [7:0] slave_mem [256];

    // Expectation model state
    logic [7:0] ref_mem [256];
    int   exp_tok[$];
    int   exp_err = 0;
    int   exp_rdata = 0;
    bit   exp_pending = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Transaction-level view of what the bus and the response must look like.
    task automatic model_cmd(input bit rw, input logic [6:0] dev, input logic [7:0] ra,
                             input logic [7:0] wd);
        exp_tok.delete();
        exp_rdata = 0;
        exp_tok.push_back(TOK_S);
        exp_tok.push_back(int'({dev, 1'b0}));
        if (dev != SLAVE_DEV) begin
            exp_tok.push_back(TOK_P);
            exp_err = 1;
        end else if (nack_reg_en) begin
            exp_tok.push_back(int'(ra));
            exp_tok.push_back(TOK_P);
            exp_err = 2;
        end else if (!rw) begin
            exp_tok.push_back(int'(ra));
            exp_tok.push_back(int'(wd));
            exp_tok.push_back(TOK_P);
            ref_mem[ra] = wd;
            exp_err = 0;
        end else begin
            exp_tok.push_back(int'(ra));
`ifndef I2C_SEQ_REPSTART_EN
            exp_tok.push_back(TOK_P);
`endif
            exp_tok.push_back(TOK_S);
            exp_tok.push_back(int'({dev, 1'b1}));
            exp_tok.push_back(int'(ref_mem[ra]));
            exp_tok.push_back(TOK_N);
            exp_tok.push_back(TOK_P);
            exp_rdata = int'(ref_mem[ra]);
            exp_err = 0;
        end
        exp_pending = 1'b1;
    endtask

    // Byte-level controller plus a single slave at SLAVE_DEV.
    initial begin : ctl_model
        int act;
        int lat_cnt;
        int byte_idx;
        logic [7:0] cur_byte;
        logic [7:0] ptr;
        act = 0; lat_cnt = 0; byte_idx = 0; cur_byte = 8'h00; ptr = 8'h00;
        for (int i = 0; i < 256; i++) slave_mem[i] = 8'(i) ^ 8'h5A;
        slave_mem[8'h22] = 8'h3C;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                act = 0;
                bus.ctl_idle     <= 1'b1;
                bus.ctl_ongoing  <= 1'b0;
                bus.ctl_ack      <= 1'b0;
                bus.ctl_nack     <= 1'b0;
                bus.ctl_data_out <= 8'h00;
            end else if (bus.ctl_start || bus.ctl_write_en || bus.ctl_send_stop ||
                         bus.ctl_send_nack) begin
                bus.ctl_idle    <= 1'b0;
                bus.ctl_ongoing <= 1'b1;
                bus.ctl_ack     <= 1'b0;
                bus.ctl_nack    <= 1'b0;
                lat_cnt = LAT;
                if (bus.ctl_start) begin
                    cur_byte = {bus.ctl_addr, bus.ctl_rw};
                    byte_idx = 0;
                    act = 1;
                    bus_log.push_back(TOK_S);
                    bus_log.push_back(int'(cur_byte));
                end else if (bus.ctl_write_en) begin
                    cur_byte = bus.ctl_data;
                    act = 2;
                    bus_log.push_back(int'(cur_byte));
                end else if (bus.ctl_send_stop) begin
                    act = 3;
                    bus_log.push_back(TOK_P);
                end else begin
                    act = 3;
                    bus_log.push_back(TOK_N);
                    bus_log.push_back(TOK_P);
                end
            end else if (act != 0 && !hang) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    bus.ctl_idle <= 1'b1;
                    if (act == 1) begin
                        if (cur_byte[7:1] == SLAVE_DEV) begin
                            bus.ctl_ack <= 1'b1;
                            if (cur_byte[0]) begin
                                bus.ctl_data_out <= slave_mem[ptr];
                                bus_log.push_back(int'(slave_mem[ptr]));
                            end
                        end else begin
                            bus.ctl_nack <= 1'b1;
                        end
                    end else if (act == 2) begin
                        if (byte_idx == 0 && nack_reg_en) begin
                            bus.ctl_nack <= 1'b1;
                        end else begin
                            bus.ctl_ack <= 1'b1;
                            if (byte_idx == 0) ptr = cur_byte;
                            else begin
                                slave_mem[ptr] = cur_byte;
                                ptr = ptr + 8'd1;
                            end
                            byte_idx++;
                        end
                    end else begin
                        bus.ctl_ongoing <= 1'b0;
                    end
                    act = 0;
                end
            end
        end
    end

    // Compare process: invariants every cycle, full transaction check on each response.
    initial begin : compare
        bit prev_rsp;
        prev_rsp = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_rsp = 1'b0;
            end else begin
                chk("pulse_onehot", int'($countones({bus.ctl_start, bus.ctl_write_en,
                    bus.ctl_send_nack, bus.ctl_send_stop, bus.ctl_read_en,
                    bus.ctl_send_ack}) <= 1), 1);
                chk("tied_low", int'({bus.ctl_read_en, bus.ctl_send_ack}), 0);
                chk("busy", int'(bus.busy), int'(!bus.cmd_ready));
                if (prev_rsp) chk("ready_after_rsp", int'(bus.cmd_ready), 1);
                if (bus.ctl_start) start_cyc = cyc;
                if (bus.rsp_valid) begin
                    rsp_cyc = cyc;
                    chk("rsp_expected", int'(exp_pending), 1);
                    chk("rsp_err", int'(bus.rsp_err), exp_err);
                    chk("rsp_rdata", int'(bus.rsp_rdata), exp_rdata);
                    chk("bus_len", bus_log.size(), exp_tok.size());
                    for (int i = 0; i < bus_log.size() && i < exp_tok.size(); i++)
                        chk("bus_tok", bus_log[i], exp_tok[i]);
                    exp_pending = 1'b0;
                end
                prev_rsp = bus.rsp_valid;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit rw, input logic [6:0] dev, input logic [7:0] ra,
                        input logic [7:0] wd, input int hold);
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 2000) begin
            tick();
            n++;
        end
        chk("ready_wait", int'(bus.cmd_ready), 1);
        bus_log.delete();
        bus.cmd_valid    = 1'b1;
        bus.cmd_rw       = rw;
        bus.cmd_dev_addr = dev;
        bus.cmd_reg_addr = ra;
        bus.cmd_wdata    = wd;
        repeat (hold) tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        while (exp_pending && n < 3000) begin
            tick();
            n++;
        end
        chk({name, "_rsp_seen"}, int'(exp_pending), 0);
        exp_pending = 1'b0;
    endtask

    task automatic chk_log(input string name, input int lit[9], input int n);
        chk({name, "_len"}, bus_log.size(), n);
        for (int i = 0; i < n && i < bus_log.size(); i++) chk(name, bus_log[i], lit[i]);
    endtask

    initial begin : main
        int lit[9];
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_rw = 1'b0;
        bus.cmd_dev_addr = 7'h00;
        bus.cmd_reg_addr = 8'h00;
        bus.cmd_wdata = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        ref_mem[8'h22] = 8'h3C;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_rsp", int'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 0);
        chk("rst_ctl_regs", int'({bus.ctl_addr, bus.ctl_rw, bus.ctl_data}), 0);
        chk("rst_pulses", int'({bus.ctl_start, bus.ctl_write_en, bus.ctl_send_nack,
                                bus.ctl_send_stop}), 0);
        tick();

        // 1: write, cmd_valid held while busy must not queue a second transaction
        model_cmd(1'b0, 7'h50, 8'h10, 8'hA5);
        send(1'b0, 7'h50, 8'h10, 8'hA5, 3);
        wait_rsp("t1");
        repeat (10) tick();
        chk("t1_no_queue", int'(bus.cmd_ready), 1);
        lit = '{TOK_S, 'hA0, 'h10, 'hA5, TOK_P, 0, 0, 0, 0};
        chk_log("t1_bus", lit, 5);

        // 2: read returns preloaded 0x3C
        model_cmd(1'b1, 7'h50, 8'h22, 8'h00);
        send(1'b1, 7'h50, 8'h22, 8'h00, 1);
        wait_rsp("t2");
`ifdef I2C_SEQ_REPSTART_EN
        lit = '{TOK_S, 'hA0, 'h22, TOK_S, 'hA1, 'h3C, TOK_N, TOK_P, 0};
        chk_log("t2_bus", lit, 8);
`else
        lit = '{TOK_S, 'hA0, 'h22, TOK_P, TOK_S, 'hA1, 'h3C, TOK_N, TOK_P};
        chk_log("t2_bus", lit, 9);
`endif
        chk("t2_rdata", int'(bus.rsp_rdata), 'h3C);

        // 3: absent device
        model_cmd(1'b0, 7'h11, 8'h05, 8'h99);
        send(1'b0, 7'h11, 8'h05, 8'h99, 1);
        wait_rsp("t3");
        lit = '{TOK_S, 'h22, TOK_P, 0, 0, 0, 0, 0, 0};
        chk_log("t3_bus", lit, 3);
        chk("t3_err", int'(bus.rsp_err), 1);

        // 4: slave NACKs the register byte
        nack_reg_en = 1'b1;
        model_cmd(1'b0, 7'h50, 8'h33, 8'h77);
        send(1'b0, 7'h50, 8'h33, 8'h77, 1);
        wait_rsp("t4");
        lit = '{TOK_S, 'hA0, 'h33, TOK_P, 0, 0, 0, 0, 0};
        chk_log("t4_bus", lit, 4);
        chk("t4_err", int'(bus.rsp_err), 2);
        nack_reg_en = 1'b0;

        // Further directed vectors checked against the model only
        model_cmd(1'b0, 7'h50, 8'h40, 8'hC3); send(1'b0, 7'h50, 8'h40, 8'hC3, 1); wait_rsp("v1");
        model_cmd(1'b1, 7'h50, 8'h40, 8'h00); send(1'b1, 7'h50, 8'h40, 8'h00, 1); wait_rsp("v2");
        model_cmd(1'b1, 7'h50, 8'h10, 8'h00); send(1'b1, 7'h50, 8'h10, 8'h00, 1); wait_rsp("v3");
        model_cmd(1'b1, 7'h12, 8'h10, 8'h00); send(1'b1, 7'h12, 8'h10, 8'h00, 1); wait_rsp("v4");
        nack_reg_en = 1'b1;
        model_cmd(1'b1, 7'h50, 8'h07, 8'h00); send(1'b1, 7'h50, 8'h07, 8'h00, 1); wait_rsp("v5");
        nack_reg_en = 1'b0;

        // 5: controller never returns idle after START -> timeout
        hang = 1'b1;
        exp_tok.delete();
        exp_tok.push_back(TOK_S);
        exp_tok.push_back('hA0);
        exp_err = 3;
        exp_rdata = 0;
        exp_pending = 1'b1;
        send(1'b0, 7'h50, 8'h01, 8'h02, 1);
        wait_rsp("t5");
        // Pulse cycle, then WAIT entry, then GUARD + TIMEOUT cycles.
        chk("t5_latency", rsp_cyc - start_cyc, 67);
        chk("t5_err", int'(bus.rsp_err), 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hang = 1'b0;
        tick();

        // 6: reset during the read data byte, then a clean write
        send(1'b1, 7'h50, 8'h22, 8'h00, 1);
        begin
            int n;
            n = 0;
            while (!(bus.ctl_start && bus.ctl_rw) && n < 2000) begin
                tick();
                n++;
            end
            chk("t6_rstart_seen", int'(bus.ctl_start && bus.ctl_rw), 1);
        end
        repeat (2) tick();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_cmd_ready", int'(bus.cmd_ready), 1);
        chk("t6_pulses", int'({bus.ctl_start, bus.ctl_write_en, bus.ctl_send_nack,
                               bus.ctl_send_stop}), 0);
        chk("t6_busy", int'(bus.busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        model_cmd(1'b0, 7'h50, 8'h55, 8'h66);
        send(1'b0, 7'h50, 8'h55, 8'h66, 1);
        wait_rsp("t6w");
        chk("t6_err", int'(bus.rsp_err), 0);

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
